// File: rtl/sn76489_pkg.sv
// Shared register indices, reset values and the tone write helper for the SN76489 command decoder.
package sn76489_pkg;

  localparam logic [2:0] SN_TONE0 = 3'd0;
  localparam logic [2:0] SN_VOL0  = 3'd1;
  localparam logic [2:0] SN_TONE1 = 3'd2;
  localparam logic [2:0] SN_VOL1  = 3'd3;
  localparam logic [2:0] SN_TONE2 = 3'd4;
  localparam logic [2:0] SN_VOL2  = 3'd5;
  localparam logic [2:0] SN_NOISE = 3'd6;
  localparam logic [2:0] SN_VOL3  = 3'd7;

  localparam logic [3:0] SN_VOL_RST   = 4'hF;
  localparam logic [9:0] SN_TONE_RST  = 10'h000;
  localparam logic [2:0] SN_NOISE_RST = 3'b000;

  // Latch bytes replace the low nibble of a tone period, data bytes the upper six bits.
  function automatic logic [9:0] sn_tone_upd(input logic [9:0] old_val, input logic [7:0] cmd);
    sn_tone_upd = cmd[7] ? {old_val[9:4], cmd[3:0]} : {cmd[5:0], old_val[3:0]};
  endfunction

endpackage

// File: rtl/sn_byte_sync.sv
// Synchronizes the receiver idle flag into clk, detects its rising edge,
// captures the received byte and emits a one-cycle decode pulse.
module sn_byte_sync
  import sn76489_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       new_data_i,
  output logic [7:0] byte_o,
  output logic       decode_o
);

  logic [2:0] sync_q;
  logic [7:0] byte_q;
  logic       decode_q;
  logic       edge_det;
  logic       capture;

  assign edge_det = sync_q[1] & ~sync_q[2];
  // An edge landing on the decode cycle is dropped; the baud rate never allows it.
  assign capture  = edge_det & ~decode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 3'b111;
      byte_q   <= 8'h00;
      decode_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], new_data_i};
      decode_q <= capture;
      if (capture) byte_q <= data_i;
    end
  end

  assign byte_o   = byte_q;
  assign decode_o = decode_q;

endmodule

// File: rtl/sn_cmd_decoder.sv
// SN76489 command byte decoder: latch/data bytes update tone, volume and noise registers.
// Optional SN_NOISE_RST_EN adds a noise_rst pulse on every noise register write.
module sn_cmd_decoder
  import sn76489_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       new_data_in,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] noise,
  output logic       wr_strobe,
`ifdef SN_NOISE_RST_EN
  output logic       noise_rst,
`endif
  output logic [2:0] wr_addr
);

  logic [7:0] byte_q;
  logic       dec_pulse;

  logic [9:0] tone_q [3];
  logic [9:0] tone_d [3];
  logic [3:0] vol_q  [4];
  logic [3:0] vol_d  [4];
  logic [2:0] noise_q, noise_d;
  logic [2:0] latch_q, latch_d;
  logic [2:0] tgt_idx;
  logic       wr_strobe_q;
  logic [2:0] wr_addr_q, wr_addr_d;

  sn_byte_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_in),
    .new_data_i (new_data_in),
    .byte_o     (byte_q),
    .decode_o   (dec_pulse)
  );

  assign tgt_idx = byte_q[7] ? byte_q[6:4] : latch_q;

  always_comb begin
    tone_d    = tone_q;
    vol_d     = vol_q;
    noise_d   = noise_q;
    latch_d   = latch_q;
    wr_addr_d = wr_addr_q;
    if (dec_pulse) begin
      wr_addr_d = tgt_idx;
      if (byte_q[7]) latch_d = byte_q[6:4];
      case (tgt_idx)
        SN_TONE0: tone_d[0] = sn_tone_upd(tone_q[0], byte_q);
        SN_TONE1: tone_d[1] = sn_tone_upd(tone_q[1], byte_q);
        SN_TONE2: tone_d[2] = sn_tone_upd(tone_q[2], byte_q);
        SN_NOISE: noise_d   = byte_q[2:0];
        default:  vol_d[tgt_idx[2:1]] = byte_q[3:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) tone_q[i] <= SN_TONE_RST;
      for (int i = 0; i < 4; i++) vol_q[i]  <= SN_VOL_RST;
      noise_q     <= SN_NOISE_RST;
      latch_q     <= SN_TONE0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 3'd0;
    end else begin
      tone_q      <= tone_d;
      vol_q       <= vol_d;
      noise_q     <= noise_d;
      latch_q     <= latch_d;
      wr_strobe_q <= dec_pulse;
      wr_addr_q   <= wr_addr_d;
    end
  end

`ifdef SN_NOISE_RST_EN
  logic noise_rst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) noise_rst_q <= 1'b0;
    else        noise_rst_q <= dec_pulse && (tgt_idx == SN_NOISE);
  end

  assign noise_rst = noise_rst_q;
`endif

  assign tone0     = tone_q[0];
  assign tone1     = tone_q[1];
  assign tone2     = tone_q[2];
  assign vol0      = vol_q[0];
  assign vol1      = vol_q[1];
  assign vol2      = vol_q[2];
  assign vol3      = vol_q[3];
  assign noise     = noise_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_sn_cmd_decoder.sv
// Directed scoreboard bench for sn_cmd_decoder: each byte sent queues its expected
// write, and a monitor pops and checks it when wr_strobe fires.
module tb_sn_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       new_data_in;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] noise;
  logic       wr_strobe;
  logic [2:0] wr_addr;
`ifdef SN_NOISE_RST_EN
  logic       noise_rst;
  int         noise_rst_cnt = 0;
`endif

  typedef struct {
    logic [2:0] addr;
    logic [9:0] val;
  } exp_t;

  exp_t q_exp[$];
  int   errors = 0;
  int   checks = 0;
  int   strobes = 0;

  sn_cmd_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .new_data_in (new_data_in),
    .tone0       (tone0),
    .tone1       (tone1),
    .tone2       (tone2),
    .vol0        (vol0),
    .vol1        (vol1),
    .vol2        (vol2),
    .vol3        (vol3),
    .noise       (noise),
    .wr_strobe   (wr_strobe),
`ifdef SN_NOISE_RST_EN
    .noise_rst   (noise_rst),
`endif
    .wr_addr     (wr_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] reg_of(input logic [2:0] a);
    case (a)
      3'd0:    reg_of = tone0;
      3'd1:    reg_of = {6'd0, vol0};
      3'd2:    reg_of = tone1;
      3'd3:    reg_of = {6'd0, vol1};
      3'd4:    reg_of = tone2;
      3'd5:    reg_of = {6'd0, vol2};
      3'd6:    reg_of = {7'd0, noise};
      default: reg_of = {6'd0, vol3};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (rst_n && wr_strobe) begin
      exp_t e;
      strobes++;
      if (q_exp.size() == 0) begin
        chk("unexpected_strobe", {7'd0, wr_addr}, 10'h3FF);
      end else begin
        e = q_exp.pop_front();
        chk("wr_addr", {7'd0, wr_addr}, {7'd0, e.addr});
        chk("reg_val", reg_of(e.addr), e.val);
`ifdef SN_NOISE_RST_EN
        chk("noise_rst", {9'd0, noise_rst}, {9'd0, e.addr == 3'd6});
`endif
      end
    end
`ifdef SN_NOISE_RST_EN
    if (noise_rst) noise_rst_cnt++;
`endif
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    new_data_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic [2:0] a, input logic [9:0] v);
    exp_t e;
    @(negedge clk);
    new_data_in = 1'b0;
    repeat (3) @(negedge clk);
    data_in = b;
    e.addr = a;
    e.val  = v;
    q_exp.push_back(e);
    new_data_in = 1'b1;
    for (int i = 0; i < 12 && q_exp.size() != 0; i++) @(negedge clk);
    if (q_exp.size() != 0) begin
      chk("timeout_no_strobe", 10'd0, 10'd1);
      q_exp.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s0;
    rst_n = 1'b0;
    data_in = 8'h00;
    new_data_in = 1'b1;
    do_reset();
    repeat (8) @(negedge clk);
    chk("rst_no_strobe", 10'(strobes), 10'd0);
    chk("rst_wr_strobe", {9'd0, wr_strobe}, 10'd0);
    chk("rst_wr_addr", {7'd0, wr_addr}, 10'd0);
    chk("rst_tone0", tone0, 10'h000);
    chk("rst_tone2", tone2, 10'h000);
    chk("rst_vol0", {6'd0, vol0}, 10'h00F);
    chk("rst_vol1", {6'd0, vol1}, 10'h00F);
    chk("rst_vol2", {6'd0, vol2}, 10'h00F);
    chk("rst_vol3", {6'd0, vol3}, 10'h00F);
    chk("rst_noise", {7'd0, noise}, 10'h000);

    send(8'h8E, 3'd0, 10'h00E);
    send(8'h0F, 3'd0, 10'h0FE);
    send(8'hD5, 3'd5, 10'h005);
    send(8'h03, 3'd5, 10'h003);
    send(8'hC4, 3'd4, 10'h004);
    send(8'h2A, 3'd4, 10'h2A4);
    send(8'hF3, 3'd7, 10'h003);
    send(8'hA9, 3'd2, 10'h009);
    send(8'hB7, 3'd3, 10'h007);
`ifdef SN_NOISE_RST_EN
    s0 = noise_rst_cnt;
`else
    s0 = 0;
`endif
    send(8'hE6, 3'd6, 10'h006);
`ifdef SN_NOISE_RST_EN
    chk("noise_rst_once", 10'(noise_rst_cnt - s0), 10'd1);
`endif
    send(8'hEE, 3'd6, 10'h006);
    send(8'h05, 3'd6, 10'h005);
    chk("hold_tone0", tone0, 10'h0FE);
    chk("hold_vol2", {6'd0, vol2}, 10'h003);
    chk("hold_vol0", {6'd0, vol0}, 10'h00F);
    chk("strobe_count", 10'(strobes), 10'd12);

    do_reset();
    send(8'h3F, 3'd0, 10'h3F0);

    @(negedge clk);
    new_data_in = 1'b0;
    repeat (3) @(negedge clk);
    data_in = 8'h9A;
    new_data_in = 1'b1;
    s0 = strobes;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_strobe", 10'(strobes - s0), 10'd0);
    chk("abort_vol0", {6'd0, vol0}, 10'h00F);
    chk("abort_tone0", tone0, 10'h000);

    send(8'h05, 3'd0, 10'h050);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
